nkmm_dspc_mac_engine: RTL and testbench

//  Parametrised multi-lane multiply-accumulate engine for the nkmm DSP core.

---
 rtl/nkmm_dspc_pkg.sv | 31 +++
 rtl/nkmm_dspc_mac_engine_if.sv | 43 ++++
 rtl/nkmm_dspc_addrgen_mask.sv | 17 +
 rtl/nkmm_dspc_mac_engine.sv | 163 ++++++++++++++++
 tb/tb_nkmm_dspc_mac_engine.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/nkmm_dspc_pkg.sv
// Shared types and defaults for the nkmm DSP MAC engine.
// Holds the sequencer state encoding and the accumulator-to-sample saturation helper.
package nkmm_dspc_pkg;

    localparam int DEF_DATA_W     = 24;
    localparam int DEF_ACC_W      = 40;
    localparam int DEF_FRAC_SHIFT = 15;
    // read + multiply + accumulate stages, plus one cycle to settle before the result is captured
    localparam int DRAIN_CYC      = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    function automatic logic signed [DEF_DATA_W-1:0] sat_to_data(input logic signed [DEF_ACC_W-1:0] acc);
        logic signed [DEF_ACC_W-1:0] hi;
        logic signed [DEF_ACC_W-1:0] lo;
        hi = {{(DEF_ACC_W-DEF_DATA_W+1){1'b0}}, {(DEF_DATA_W-1){1'b1}}};
        lo = ~hi;
        if (acc > hi) begin
            return hi[DEF_DATA_W-1:0];
        end else if (acc < lo) begin
            return lo[DEF_DATA_W-1:0];
        end
        return acc[DEF_DATA_W-1:0];
    endfunction

endpackage

// File: rtl/nkmm_dspc_mac_engine_if.sv
// Run control, memory write ports and result bus of the MAC engine.
// master drives run/write requests; slave is the engine.
interface nkmm_dspc_mac_engine_if #(
    parameter int LANES    = 4,
    parameter int DATA_W   = 24,
    parameter int CAND_AW  = 8,
    parameter int PLIER_AW = 12
);
    logic                      start_i;
    logic [PLIER_AW:0]         len_i;
    logic [CAND_AW-1:0]        cand_base_i;
    logic [CAND_AW-1:0]        cand_mask_i;
    logic                      cand_dec_i;
    logic [PLIER_AW-1:0]       plier_base_i;
    logic [PLIER_AW-1:0]       plier_mask_i;
    logic                      plier_dec_i;
    logic                      cand_we_i;
    logic [CAND_AW-1:0]        cand_waddr_i;
    logic [LANES*DATA_W-1:0]   cand_wdata_i;
    logic                      plier_we_i;
    logic [PLIER_AW-1:0]       plier_waddr_i;
    logic [LANES*DATA_W-1:0]   plier_wdata_i;
    logic                      busy_o;
    logic                      done_o;
    logic [LANES*DATA_W-1:0]   result_o;

    modport master (
        output start_i, len_i, cand_base_i, cand_mask_i, cand_dec_i,
               plier_base_i, plier_mask_i, plier_dec_i,
               cand_we_i, cand_waddr_i, cand_wdata_i,
               plier_we_i, plier_waddr_i, plier_wdata_i,
        input  busy_o, done_o, result_o
    );

    modport slave (
        input  start_i, len_i, cand_base_i, cand_mask_i, cand_dec_i,
               plier_base_i, plier_mask_i, plier_dec_i,
               cand_we_i, cand_waddr_i, cand_wdata_i,
               plier_we_i, plier_waddr_i, plier_wdata_i,
        output busy_o, done_o, result_o
    );

endinterface

// File: rtl/nkmm_dspc_addrgen_mask.sv
// Masked circular next-address logic: only bits set in mask_i may change.
// Purely combinational; carries from the +/-1 step are discarded outside the mask.
module nkmm_dspc_addrgen_mask #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] cur_i,
    input  logic [WIDTH-1:0] mask_i,
    input  logic             dec_i,
    output logic [WIDTH-1:0] nxt_o
);

    logic [WIDTH-1:0] step;

    assign step  = dec_i ? (cur_i - WIDTH'(1)) : (cur_i + WIDTH'(1));
    assign nxt_o = (cur_i & ~mask_i) | (step & mask_i);

endmodule

// File: rtl/nkmm_dspc_mac_engine.sv
// LANES-wide dot-product engine: address gen -> 1-cycle memory read -> multiply -> accumulate.
// done_o pulses N+4 cycles after start is accepted; start_i is ignored while busy_o is high.
module nkmm_dspc_mac_engine
    import nkmm_dspc_pkg::*;
#(
    parameter int LANES      = 4,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ACC_W      = DEF_ACC_W,
    parameter int CAND_AW    = 8,
    parameter int PLIER_AW   = 12,
    parameter int FRAC_SHIFT = DEF_FRAC_SHIFT
) (
    input  logic                    clk,
    input  logic                    rst,
    nkmm_dspc_mac_engine_if.slave   bus
);

    localparam int CNT_W = PLIER_AW + 1;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CAND_AW-1:0]    cand_addr_q, cand_addr_d, cand_nxt;
    logic [PLIER_AW-1:0]   plier_addr_q, plier_addr_d, plier_nxt;
    logic [CAND_AW-1:0]    cand_mask_q;
    logic [PLIER_AW-1:0]   plier_mask_q;
    logic                  cand_dec_q, plier_dec_q;
    logic                  rd_vld_q, prod_vld_q;
    logic                  start_acc;
    logic                  res_upd;

    nkmm_dspc_addrgen_mask #(.WIDTH(CAND_AW)) u_cand_ag (
        .cur_i  (cand_addr_q),
        .mask_i (cand_mask_q),
        .dec_i  (cand_dec_q),
        .nxt_o  (cand_nxt)
    );

    nkmm_dspc_addrgen_mask #(.WIDTH(PLIER_AW)) u_plier_ag (
        .cur_i  (plier_addr_q),
        .mask_i (plier_mask_q),
        .dec_i  (plier_dec_q),
        .nxt_o  (plier_nxt)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cand_addr_d  = cand_addr_q;
        plier_addr_d = plier_addr_q;
        start_acc    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    start_acc    = 1'b1;
                    cand_addr_d  = bus.cand_base_i;
                    plier_addr_d = bus.plier_base_i;
                    if (bus.len_i == '0) begin
                        state_d = DRAIN;
                        cnt_d   = CNT_W'(DRAIN_CYC - 1);
                    end else begin
                        state_d = RUN;
                        cnt_d   = bus.len_i;
                    end
                end
            end
            RUN: begin
                cand_addr_d  = cand_nxt;
                plier_addr_d = plier_nxt;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DRAIN;
                    cnt_d   = CNT_W'(DRAIN_CYC - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            cand_addr_q  <= '0;
            plier_addr_q <= '0;
            cand_mask_q  <= '0;
            plier_mask_q <= '0;
            cand_dec_q   <= 1'b0;
            plier_dec_q  <= 1'b0;
            rd_vld_q     <= 1'b0;
            prod_vld_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cand_addr_q  <= cand_addr_d;
            plier_addr_q <= plier_addr_d;
            rd_vld_q     <= (state_q == RUN);
            prod_vld_q   <= rd_vld_q;
            if (start_acc) begin
                cand_mask_q  <= bus.cand_mask_i;
                plier_mask_q <= bus.plier_mask_i;
                cand_dec_q   <= bus.cand_dec_i;
                plier_dec_q  <= bus.plier_dec_i;
            end
        end
    end

    // the last accumulate lands two edges before this, so the capture is always settled
    assign res_upd     = (state_q == DRAIN) && (cnt_q == '0);
    assign bus.busy_o  = (state_q != IDLE);
    assign bus.done_o  = (state_q == DONE);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic signed [DATA_W-1:0]   cand_mem  [2**CAND_AW];
        logic signed [DATA_W-1:0]   plier_mem [2**PLIER_AW];
        logic signed [DATA_W-1:0]   cand_rd_q, plier_rd_q;
        logic signed [2*DATA_W-1:0] prod_q, prod_sh;
        logic signed [ACC_W-1:0]    acc_q;
        logic        [DATA_W-1:0]   res_q;

        // storage and read/multiply pipeline carry no reset; validity is tracked by the sequencer
        always_ff @(posedge clk) begin
            if (bus.cand_we_i) begin
                cand_mem[bus.cand_waddr_i] <= bus.cand_wdata_i[l*DATA_W +: DATA_W];
            end
            if (bus.plier_we_i) begin
                plier_mem[bus.plier_waddr_i] <= bus.plier_wdata_i[l*DATA_W +: DATA_W];
            end
            cand_rd_q  <= cand_mem[cand_addr_q];
            plier_rd_q <= plier_mem[plier_addr_q];
            prod_q     <= (2*DATA_W)'(cand_rd_q) * (2*DATA_W)'(plier_rd_q);
        end

        assign prod_sh = prod_q >>> FRAC_SHIFT;

        always_ff @(posedge clk) begin
            if (rst) begin
                acc_q <= '0;
                res_q <= '0;
            end else begin
                if (start_acc) begin
                    acc_q <= '0;
                end else if (prod_vld_q) begin
                    acc_q <= acc_q + ACC_W'(prod_sh);
                end
                if (res_upd) begin
                    res_q <= sat_to_data(acc_q);
                end
            end
        end

        assign bus.result_o[l*DATA_W +: DATA_W] = res_q;
    end

endmodule

// File: tb/tb_nkmm_dspc_mac_engine.sv
// Randomised bench for nkmm_dspc_mac_engine against a shadow-memory dot-product model.
module tb_nkmm_dspc_mac_engine;

    localparam int LANES = 4;
    localparam int DW    = 24;
    localparam int CAW   = 8;
    localparam int PAW   = 12;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nkmm_dspc_mac_engine_if #(.LANES(LANES), .DATA_W(DW), .CAND_AW(CAW), .PLIER_AW(PAW)) bus ();

    nkmm_dspc_mac_engine #(
        .LANES(LANES), .DATA_W(DW), .ACC_W(40), .CAND_AW(CAW), .PLIER_AW(PAW), .FRAC_SHIFT(15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DW-1:0] cand_m  [LANES][256];
    logic [DW-1:0] plier_m [LANES][4096];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int step(input int cur, input int mask, input bit dec, input int w);
        int s;
        s = dec ? cur - 1 : cur + 1;
        return ((cur & ~mask) | (s & mask)) & ((1 << w) - 1);
    endfunction

    // Dot product of the addressed words, each product scaled by 2^-15, 40-bit wrap, then clamp.
    function automatic logic [DW-1:0] model(input int lane, input int n,
                                            input int cb, input int cm, input bit cd,
                                            input int pb, input int pm, input bit pd);
        longint acc, a, b;
        int ca, pa;
        acc = 0;
        ca  = cb;
        pa  = pb;
        for (int i = 0; i < n; i++) begin
            a   = longint'($signed(cand_m[lane][ca]));
            b   = longint'($signed(plier_m[lane][pa]));
            acc = acc + ((a * b) >>> 15);
            acc = (acc <<< 24) >>> 24;
            ca  = step(ca, cm, cd, CAW);
            pa  = step(pa, pm, pd, PAW);
        end
        if (acc > 64'sd8388607)  return 24'h7FFFFF;
        if (acc < -64'sd8388608) return 24'h800000;
        return acc[DW-1:0];
    endfunction

    task automatic wr(input bit c_en, input int ca, input logic [DW-1:0] cv,
                      input bit p_en, input int pa, input logic [DW-1:0] pv, input bit rnd);
        logic [DW-1:0] c, p;
        @(negedge clk);
        bus.cand_we_i     = c_en;
        bus.cand_waddr_i  = CAW'(ca);
        bus.plier_we_i    = p_en;
        bus.plier_waddr_i = PAW'(pa);
        for (int l = 0; l < LANES; l++) begin
            c = rnd ? DW'($urandom) : cv;
            p = rnd ? DW'($urandom) : pv;
            bus.cand_wdata_i[l*DW +: DW]  = c;
            bus.plier_wdata_i[l*DW +: DW] = p;
            if (c_en) cand_m[l][ca]  = c;
            if (p_en) plier_m[l][pa] = p;
        end
        @(posedge clk);
        #1;
        bus.cand_we_i  = 1'b0;
        bus.plier_we_i = 1'b0;
    endtask

    task automatic run(input int n, input int cb, input int cm, input bit cd,
                       input int pb, input int pm, input bit pd,
                       input string tag, input bit pulse_start, output logic [DW-1:0] r0);
        logic [DW-1:0] exp_r [LANES];
        int  lat, extra;
        bit  got;
        for (int l = 0; l < LANES; l++) exp_r[l] = model(l, n, cb, cm, cd, pb, pm, pd);
        @(negedge clk);
        bus.len_i        = (PAW+1)'(n);
        bus.cand_base_i  = CAW'(cb);
        bus.cand_mask_i  = CAW'(cm);
        bus.cand_dec_i   = cd;
        bus.plier_base_i = PAW'(pb);
        bus.plier_mask_i = PAW'(pm);
        bus.plier_dec_i  = pd;
        bus.start_i      = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        chk({tag, "_busy"}, bus.busy_o, 1);
        lat = 0;
        got = 0;
        for (int c = 1; c <= n + 40 && !got; c++) begin
            if (pulse_start && c == 2) begin
                @(negedge clk);
                bus.start_i     = 1'b1;
                bus.len_i       = 13'd3;
                bus.cand_base_i = 8'h55;
            end
            @(posedge clk);
            #1;
            bus.start_i = 1'b0;
            if (bus.done_o) begin
                got = 1;
                lat = c;
            end
        end
        chk({tag, "_lat"}, lat, n + 4);
        for (int l = 0; l < LANES; l++)
            chk($sformatf("%s_res%0d", tag, l), bus.result_o[l*DW +: DW], exp_r[l]);
        r0 = bus.result_o[DW-1:0];
        @(posedge clk);
        #1;
        chk({tag, "_done_lo"}, bus.done_o, 0);
        chk({tag, "_busy_lo"}, bus.busy_o, 0);
        if (pulse_start) begin
            extra = 0;
            repeat (12) begin
                @(posedge clk);
                #1;
                if (bus.done_o) extra++;
            end
            chk({tag, "_extra_done"}, extra, 0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] r0;
        int ndone;
        rst = 1'b1;
        bus.start_i = 0; bus.len_i = '0;
        bus.cand_base_i = '0; bus.cand_mask_i = '0; bus.cand_dec_i = 0;
        bus.plier_base_i = '0; bus.plier_mask_i = '0; bus.plier_dec_i = 0;
        bus.cand_we_i = 0; bus.cand_waddr_i = '0; bus.cand_wdata_i = '0;
        bus.plier_we_i = 0; bus.plier_waddr_i = '0; bus.plier_wdata_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_done", bus.done_o, 0);
        for (int l = 0; l < LANES; l++) chk($sformatf("rst_res%0d", l), bus.result_o[l*DW +: DW], 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 4096; i++) wr(i < 256, i, '0, 1, i, '0, 1);

        // basic sum: 1.0 * (1..8) = 36
        for (int k = 0; k < 8; k++) wr(1, k, 24'h008000, 1, k, DW'(k + 1), 0);
        run(8, 0, 'hFF, 0, 0, 'hFFF, 0, "basic", 0, r0);
        chk("basic_36", r0, 36);

        run(4, 'h10, 'hFF, 0, 'h0FE, 'h00F, 0, "pwrap", 0, r0);
        run(3, 'h00, 'hFF, 1, 'h020, 'hFFF, 0, "cdec", 0, r0);

        for (int k = 0; k < 4; k++) wr(1, 'h40 + k, 24'h7FFFFF, 1, 'h100 + k, 24'h7FFFFF, 0);
        run(4, 'h40, 'hFF, 0, 'h100, 'hFFF, 0, "satp", 0, r0);
        chk("satp_max", r0, 24'h7FFFFF);
        for (int k = 0; k < 4; k++) wr(1, 'h40 + k, 24'h800000, 0, 0, '0, 0);
        run(4, 'h40, 'hFF, 0, 'h100, 'hFFF, 0, "satn", 0, r0);
        chk("satn_min", r0, 24'h800000);

        run(8, 0, 'hFF, 0, 0, 'hFFF, 0, "ignstart", 1, r0);
        chk("ignstart_36", r0, 36);

        // reset sampled at E0+3 aborts the run
        @(negedge clk);
        bus.len_i = 13'd8; bus.cand_base_i = '0; bus.cand_mask_i = 8'hFF; bus.cand_dec_i = 0;
        bus.plier_base_i = '0; bus.plier_mask_i = 12'hFFF; bus.plier_dec_i = 0;
        bus.start_i = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_busy", bus.busy_o, 0);
        chk("mrst_done", bus.done_o, 0);
        for (int l = 0; l < LANES; l++) chk($sformatf("mrst_res%0d", l), bus.result_o[l*DW +: DW], 0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (16) begin
            @(posedge clk);
            #1;
            if (bus.done_o) ndone++;
        end
        chk("mrst_nodone", ndone, 0);
        run(8, 0, 'hFF, 0, 0, 'hFFF, 0, "fresh", 0, r0);
        chk("fresh_36", r0, 36);

        run(0, 0, 'hFF, 0, 0, 'hFFF, 0, "zero", 0, r0);
        chk("zero_res", r0, 0);

        fork
            run(8, 0, 'hFF, 0, 0, 'hFFF, 0, "wrun", 0, r0);
            begin
                repeat (3) @(posedge clk);
                wr(1, 'h80, '0, 1, 'h800, '0, 1);
            end
        join
        chk("wrun_36", r0, 36);

        for (int t = 0; t < 12; t++) begin
            run($urandom_range(0, 40), $urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom),
                $urandom_range(0, 4095), $urandom_range(0, 4095), 1'($urandom),
                $sformatf("rnd%0d", t), 0, r0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
